// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: RW control registers with byte strobes, RO status registers
// sampled from the datapath, per-register write pulses and SLVERR on out-of-range addresses.
module axil_reg_bank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0] RO_MASK    = 8'hC0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                     s_axi_awprot,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                     s_axi_arprot,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic                           dbg_wr_state_o,
    output logic                           dbg_rd_state_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int HI     = LSB + IDX_W;

    localparam logic WR_IDLE = 1'b0;
    localparam logic WR_RESP = 1'b1;
    localparam logic RD_IDLE = 1'b0;
    localparam logic RD_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Readies are registered, so they never depend combinationally on the master's valids.

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] upper;
        upper = a >> HI;
        return (upper == '0) && (int'(a[LSB +: IDX_W]) < NUM_REGS);
    endfunction

    logic                  wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;
    logic [STRB_W-1:0]     ws;
    logic [IDX_W-1:0]      widx, ridx;

    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid && wready_q;
    // The commit edge may coincide with either handshake, so take whichever copy is current.
    assign wa    = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign wd    = w_held_q ? wdata_q : s_axi_wdata;
    assign ws    = w_held_q ? wstrb_q : s_axi_wstrb;
    assign widx  = wa[LSB +: IDX_W];
    assign ridx  = s_axi_araddr[LSB +: IDX_W];

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_RESP;
                    bvalid_d   = 1'b1;
                    if (!addr_ok(wa)) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        bresp_d = RESP_OKAY;
                        if (!RO_MASK[widx]) begin
                            for (int k = 0; k < STRB_W; k++) begin
                                if (ws[k]) regs_d[widx][k*8 +: 8] = wd[k*8 +: 8];
                            end
                            wr_pulse_d[widx] = 1'b1;
                        end
                    end
                end else begin
                    awready_d = !(aw_held_q || aw_hs);
                    wready_d  = !(w_held_q || w_hs);
                end
            end
            WR_RESP: begin
                // Readies come back one edge after the B handshake.
                if (s_axi_bready) begin
                    wr_state_d = WR_IDLE;
                    bvalid_d   = 1'b0;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    rd_state_d = RD_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    if (!addr_ok(s_axi_araddr)) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rresp_d = RESP_OKAY;
                        rdata_d = RO_MASK[ridx] ? status_in[ridx*DATA_WIDTH +: DATA_WIDTH]
                                                : regs_q[ridx];
                    end
                end
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    rd_state_d = RD_IDLE;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign s_axi_awready  = awready_q;
    assign s_axi_wready   = wready_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_bresp    = bresp_q;
    assign s_axi_arready  = arready_q;
    assign s_axi_rvalid   = rvalid_q;
    assign s_axi_rdata    = rdata_q;
    assign s_axi_rresp    = rresp_q;
    assign wr_pulse       = wr_pulse_q;
    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot};

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: a table of single read/write transactions with hand-computed
// results, followed by hand-written sequences for stalls, reset during a response and concurrency.
module tb_axil_reg_bank;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;
    logic [NR*DW-1:0] reg_out, status_in;
    logic [NR-1:0]   wr_pulse;
    logic            dbg_wr_state, dbg_rd_state;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    axil_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(8'hC0)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse),
        .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
    );

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [DW-1:0] rdata;
        logic [NR-1:0] pulse;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [NR-1:0] pulse_or, output int pulse_n);
        bit done, aw_f, w_f, b_f;
        done = 0; resp = 2'b11; pulse_or = '0; pulse_n = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            b_f  = bvalid && bready;
            if (bvalid) resp = bresp;
            pulse_or |= wr_pulse;
            pulse_n  += $countones(wr_pulse);
            @(negedge clk);
            if (aw_f) awvalid = 1'b0;
            if (w_f) wvalid = 1'b0;
            if (b_f) done = 1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        chk("write_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
        bit done, ar_f, r_f;
        done = 0; data = '0; resp = 2'b11;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            ar_f = arvalid && arready;
            r_f  = rvalid && rready;
            if (rvalid) begin
                data = rdata;
                resp = rresp;
            end
            @(negedge clk);
            if (ar_f) arvalid = 1'b0;
            if (r_f) done = 1;
        end
        arvalid = 1'b0; rready = 1'b0;
        chk("read_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (awready && wready && arready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_timeout", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    resp;
        logic [NR-1:0] pulse_or;
        int            pulse_n;
        logic [DW-1:0] data, expd;

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        status_in = '0;
        status_in[7*DW +: DW] = 32'hDEADBEEF;
        status_in[6*DW +: DW] = 32'h12345678;
        status_in[0*DW +: DW] = 32'hFFFFFFFF;
        status_in[1*DW +: DW] = 32'h0BAD0BAD;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_reg_out", {56'd0, |reg_out, wr_pulse}, 64'd0);
        chk("rst_rdata", {30'd0, rresp, rdata}, 64'd0);
        rst_n = 1'b1;
        chk("rel_wready_before_edge", {63'd0, wready}, 64'd0);
        @(negedge clk);
        chk("rel_readies_up", {61'd0, awready, wready, arready}, 64'd7);

        vq.push_back('{1, 6'h00, 32'h1,        4'hF, 2'b00, 32'h0,        8'h01, "t1_w0"});
        vq.push_back('{1, 6'h04, 32'h2,        4'hF, 2'b00, 32'h0,        8'h02, "t1_w1"});
        vq.push_back('{1, 6'h08, 32'h3,        4'hF, 2'b00, 32'h0,        8'h04, "t1_w2"});
        vq.push_back('{1, 6'h0C, 32'h4,        4'hF, 2'b00, 32'h0,        8'h08, "t1_w3"});
        vq.push_back('{0, 6'h00, 32'h0,        4'h0, 2'b00, 32'h1,        8'h00, "t1_r0"});
        vq.push_back('{0, 6'h04, 32'h0,        4'h0, 2'b00, 32'h2,        8'h00, "t1_r1"});
        vq.push_back('{0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h3,        8'h00, "t1_r2"});
        vq.push_back('{0, 6'h0C, 32'h0,        4'h0, 2'b00, 32'h4,        8'h00, "t1_r3"});
        vq.push_back('{1, 6'h04, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0,        8'h02, "t2_wfull"});
        vq.push_back('{1, 6'h04, 32'h11223344, 4'h5, 2'b00, 32'h0,        8'h02, "t2_wstrb"});
        vq.push_back('{0, 6'h04, 32'h0,        4'h0, 2'b00, 32'hAA22CC44, 8'h00, "t2_r"});
        vq.push_back('{1, 6'h1C, 32'h55,       4'hF, 2'b00, 32'h0,        8'h00, "t3_w_ro"});
        vq.push_back('{0, 6'h1C, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 8'h00, "t3_r_ro7"});
        vq.push_back('{0, 6'h18, 32'h0,        4'h0, 2'b00, 32'h12345678, 8'h00, "t3_r_ro6"});
        vq.push_back('{1, 6'h20, 32'h66,       4'hF, 2'b10, 32'h0,        8'h00, "t4_w_oor"});
        vq.push_back('{0, 6'h20, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00, "t4_r_oor"});
        vq.push_back('{0, 6'h3C, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00, "t4_r_oor_top"});
        vq.push_back('{0, 6'h06, 32'h0,        4'h0, 2'b00, 32'hAA22CC44, 8'h00, "lowbits_ignored"});

        foreach (vq[i]) begin
            if (vq[i].wr) begin
                axi_write(vq[i].addr, vq[i].data, vq[i].strb, resp, pulse_or, pulse_n);
                chk({vq[i].name, "_bresp"}, {62'd0, resp}, {62'd0, vq[i].resp});
                chk({vq[i].name, "_pulse"}, {56'd0, pulse_or}, {56'd0, vq[i].pulse});
                chk({vq[i].name, "_npulse"}, 64'(pulse_n), 64'($countones(vq[i].pulse)));
            end else begin
                exp_q.push_back(vq[i].rdata);
                axi_read(vq[i].addr, data, resp);
                expd = exp_q.pop_front();
                chk({vq[i].name, "_rdata"}, {32'd0, data}, {32'd0, expd});
                chk({vq[i].name, "_rresp"}, {62'd0, resp}, {62'd0, vq[i].resp});
            end
        end

        chk("reg_out0", {32'd0, reg_out[0*DW +: DW]}, 64'h1);
        chk("reg_out1", {32'd0, reg_out[1*DW +: DW]}, 64'hAA22CC44);
        chk("reg_out3", {32'd0, reg_out[3*DW +: DW]}, 64'h4);
        chk("reg_out_ro", {32'd0, reg_out[7*DW +: DW] | reg_out[6*DW +: DW]}, 64'h0);

        // AW four cycles ahead of W, then B stalled for five cycles
        wait_ready();
        awaddr = 6'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("t5_awready_held", {62'd0, awready, wready}, 64'd1);
        repeat (3) @(negedge clk);
        chk("t5_aw_wait", {62'd0, awready, bvalid}, 64'd0);
        wdata = 32'h00005A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("t5_bvalid", {61'd0, bvalid, bresp}, 64'h4);
        chk("t5_pulse", {56'd0, wr_pulse}, 64'h04);
        chk("t5_reg_out2", {32'd0, reg_out[2*DW +: DW]}, 64'h5A5A);
        chk("t5_dbg_state", {63'd0, dbg_wr_state}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_stall", {58'd0, bvalid, bresp, awready, wready, wr_pulse[2]}, 64'h20);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("t5_b_done", {62'd0, bvalid, awready}, 64'd0);
        @(negedge clk);
        chk("t5_ready_back", {62'd0, awready, wready}, 64'd3);

        // Reset during a pending write response
        awaddr = 6'h00; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t6_pre_bvalid", {63'd0, bvalid}, 64'd1);
        chk("t6_pre_reg0", {32'd0, reg_out[0*DW +: DW]}, 64'h7);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bvalid", {62'd0, bvalid, awready}, 64'd0);
        chk("t6_rst_reg0", {32'd0, reg_out[0*DW +: DW]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(6'h00, data, resp);
        chk("t6_read_reg0", {30'd0, resp, data}, 64'h0);
        axi_write(6'h0C, 32'h99, 4'hF, resp, pulse_or, pulse_n);
        chk("t6_write_ok", {54'd0, resp, pulse_or}, {54'd0, 2'b00, 8'h08});
        chk("t6_reg_out3", {32'd0, reg_out[3*DW +: DW]}, 64'h99);

        // Read captured on the same edge as a commit to the same register returns the old value
        @(negedge clk);
        wait_ready();
        awaddr = 6'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 6'h0C; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("conc_valids", {62'd0, bvalid, rvalid}, 64'd3);
        chk("conc_old_data", {32'd0, rdata}, 64'h99);
        chk("conc_new_reg", {32'd0, reg_out[3*DW +: DW]}, 64'h77);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        axi_read(6'h0C, data, resp);
        chk("conc_readback", {30'd0, resp, data}, 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
